// File: rtl/pid_pkg.sv
// Shared definitions for the plant emulator: FSM encoding, Q8.8 constants and a
// generic signed saturation helper.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_U,
    DELAY,
    UPDATE,
    EMIT
  } state_t;

  localparam logic signed [15:0] ONE  = 16'sh0100;
  localparam logic signed [15:0] HALF = 16'sh0080;

  // Wide enough for any MAC result the emulator produces.
  localparam int ACC_W = 48;
  localparam logic signed [ACC_W-1:0] ACC_ONE = 1;

  typedef struct packed {
    logic signed [ACC_W-1:0] value;
    logic                    clipped;
  } sat_t;

  // Clamp v into the signed range of a width-bit word.
  function automatic sat_t sat_signed(input logic signed [ACC_W-1:0] v,
                                      input int unsigned width);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    sat_t r;
    hi = (ACC_ONE <<< (width - 1)) - ACC_ONE;
    lo = -hi - ACC_ONE;
    r.value   = v;
    r.clipped = 1'b0;
    if (v > hi) begin
      r.value   = hi;
      r.clipped = 1'b1;
    end else if (v < lo) begin
      r.value   = lo;
      r.clipped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/plant_emulator_if.sv
// Sample path between controller and plant: u goes in, y comes back.
interface plant_emulator_if #(
  parameter int DATA_WIDTH = 16
);
  // u transfers on a clock edge where u_valid and u_ready are both high; the
  // master holds u_in stable while u_valid is high. y_valid is a one-cycle
  // pulse with no back-pressure, and y_out holds between pulses.
  logic signed [DATA_WIDTH-1:0] u_in;
  logic                         u_valid;
  logic                         u_ready;
  logic signed [DATA_WIDTH-1:0] y_out;
  logic                         y_valid;

  modport master (output u_in, u_valid, input u_ready, y_out, y_valid);
  modport slave  (input u_in, u_valid, output u_ready, y_out, y_valid);
endinterface

// File: rtl/plant_emulator_delay_ring.sv
// Register-file ring buffer with a write pointer and a combinational tap at a
// programmable distance behind it; offset 0 bypasses to the write data.
module delay_ring #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    offset,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_idx;

  // DEPTH is a power of two, so the subtraction wraps naturally.
  assign rd_idx  = wr_ptr - offset;
  assign rd_data = (offset == '0) ? wr_data : mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/plant_emulator.sv
// First-order plant with dead time, y[n] = a*y[n-1] + b*u[n-d], advanced once
// per sample tick. Closes the loop around a controller in HIL tests.
module plant_emulator
  import pid_pkg::*;
#(
  parameter  int DATA_WIDTH  = 16,
  parameter  int FRAC_BITS   = 8,
  parameter  int DELAY_DEPTH = 16,
  parameter  int DIV_WIDTH   = 16,
  localparam int DA          = $clog2(DELAY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  sample_div,
  input  logic signed [15:0]    coef_a,
  input  logic signed [15:0]    coef_b,
  input  logic [DA-1:0]         delay_len,
  plant_emulator_if.slave       bus,
  output logic                  sat,
  output logic                  overrun,
  output state_t                dbg_state
);

  state_t                          state;
  logic [DIV_WIDTH-1:0]            cnt;
  logic                            tick;
  logic signed [DATA_WIDTH-1:0]    u_q;
  logic signed [DATA_WIDTH-1:0]    ud_q;
  logic signed [DATA_WIDTH-1:0]    y_q;
  logic                            y_valid_q;
  logic                            u_ready_q;
  logic                            sat_q;
  logic                            overrun_q;
  logic [DATA_WIDTH-1:0]           ring_rd;
  logic signed [DATA_WIDTH+15:0]   prod_a;
  logic signed [DATA_WIDTH+15:0]   prod_b;
  logic signed [DATA_WIDTH+16:0]   acc;
  logic signed [DATA_WIDTH+16:0]   acc_sh;
  sat_t                            sr;
  logic                            unused_sat_hi;

  assign tick = enable && (cnt == sample_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (!enable)     cnt <= '0;
    else if (tick)        cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // The ring only advances when DELAY completes with enable still high.
  delay_ring #(
    .DEPTH (DELAY_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (enable && (state == DELAY)),
    .wr_data (u_q),
    .offset  (delay_len),
    .rd_data (ring_rd)
  );

  assign prod_a = coef_a * y_q;
  assign prod_b = coef_b * ud_q;
  assign acc    = {prod_a[DATA_WIDTH+15], prod_a} + {prod_b[DATA_WIDTH+15], prod_b};
  assign acc_sh = acc >>> FRAC_BITS;
  assign sr     = sat_signed(ACC_W'(acc_sh), DATA_WIDTH);
  assign unused_sat_hi = ^sr.value[ACC_W-1:DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      u_q       <= '0;
      ud_q      <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      u_ready_q <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      // Dropped ticks are flagged but never disturb the sample in progress.
      if (tick && state != IDLE) overrun_q <= 1'b1;
      if (!enable) begin
        state     <= IDLE;
        u_ready_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tick) begin
              state     <= WAIT_U;
              u_ready_q <= 1'b1;
            end
          end
          WAIT_U: begin
            if (bus.u_valid && u_ready_q) begin
              u_q       <= bus.u_in;
              u_ready_q <= 1'b0;
              state     <= DELAY;
            end
          end
          DELAY: begin
            ud_q  <= $signed(ring_rd);
            state <= UPDATE;
          end
          UPDATE: begin
            y_q       <= sr.value[DATA_WIDTH-1:0];
            y_valid_q <= 1'b1;
            if (sr.clipped) sat_q <= 1'b1;
            state     <= EMIT;
          end
          EMIT: begin
            state <= IDLE;
          end
          default: begin
            state     <= IDLE;
            u_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.u_ready = u_ready_q;
  assign bus.y_out   = y_q;
  assign bus.y_valid = y_valid_q;
  assign sat         = sat_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_plant_emulator.sv
// Bench for plant_emulator: directed scenarios with literal expectations plus
// randomized traffic, all checked against a transaction-level plant model.
module tb_plant_emulator;
  import pid_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [15:0]        sample_div = '0;
  logic signed [15:0] coef_a = '0;
  logic signed [15:0] coef_b = '0;
  logic [3:0]         delay_len = '0;
  logic               sat;
  logic               overrun;
  state_t             dbg_state;

  plant_emulator_if #(.DATA_WIDTH(16)) bus();

  plant_emulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sample_div (sample_div),
    .coef_a     (coef_a),
    .coef_b     (coef_b),
    .delay_len  (delay_len),
    .bus        (bus),
    .sat        (sat),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          exp_due_q[$];
  bit          exp_clip_q[$];
  longint      hist[$];
  longint      y_model = 0;
  longint      y_last = 0;
  bit          sat_exp = 1'b0;
  longint      obs_y_q[$];
  int          obs_t_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plant rules: the sample taken d handshakes ago (0 if never written),
  // y = clamp(floor((a*y_prev + b*ud) / 256)).
  task automatic model_step(input logic signed [15:0] u);
    longint ud;
    longint acc;
    int     d;
    bit     clip;
    d = int'(delay_len);
    if (d == 0)                ud = u;
    else if (hist.size() >= d) ud = hist[hist.size() - d];
    else                       ud = 0;
    hist.push_back(longint'(u));
    acc  = longint'(coef_a) * y_model + longint'(coef_b) * ud;
    acc  = acc >>> 8;
    clip = 1'b0;
    if (acc > 32767) begin
      acc = 32767; clip = 1'b1;
    end else if (acc < -32768) begin
      acc = -32768; clip = 1'b1;
    end
    y_model = acc;
    exp_q.push_back(acc[15:0]);
    exp_due_q.push_back(cyc + 3);
    exp_clip_q.push_back(clip);
  endtask

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.u_valid && bus.u_ready) model_step(bus.u_in);
      if (bus.y_valid) begin
        obs_y_q.push_back(longint'(bus.y_out));
        obs_t_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("y_unexpected", longint'(exp_q.size()), 1);
        end else begin
          logic [15:0] e;
          int          due;
          bit          clip;
          e    = exp_q.pop_front();
          due  = exp_due_q.pop_front();
          clip = exp_clip_q.pop_front();
          check("y_out", longint'(bus.y_out), longint'($signed(e)));
          check("y_latency", cyc, due);
          y_last = longint'($signed(e));
          if (clip) sat_exp = 1'b1;
        end
      end else begin
        check("y_hold", longint'(bus.y_out), y_last);
        if (exp_q.size() != 0 && cyc > exp_due_q[0]) begin
          check("y_timeout", cyc, exp_due_q[0]);
          void'(exp_q.pop_front());
          void'(exp_due_q.pop_front());
          void'(exp_clip_q.pop_front());
        end
      end
      check("sat", longint'(sat), longint'(sat_exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    exp_q.delete(); exp_due_q.delete(); exp_clip_q.delete();
    hist.delete(); obs_y_q.delete(); obs_t_q.delete();
    y_model = 0; y_last = 0; sat_exp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    bus.u_valid = 1'b0;
    bus.u_in = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_u(input logic signed [15:0] v, output int hs_cyc);
    bit done;
    done = 1'b0;
    hs_cyc = -1;
    bus.u_in = v;
    bus.u_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.u_ready) begin
        done = 1'b1;
        hs_cyc = cyc;
      end
    end
    if (!done) check("u_ready_timeout", longint'(done), 1);
    @(posedge clk); #1;
    bus.u_valid = 1'b0;
  endtask

  task automatic wait_y(input int n);
    for (int i = 0; i < 400 && obs_y_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    check("y_count", obs_y_q.size(), n);
  endtask

  function automatic longint obs_y(input int i);
    return (i < obs_y_q.size()) ? obs_y_q[i] : -99999;
  endfunction

  // ---------------- stimulus ----------------
  int hs;
  int n0;
  longint y_save;
  int total;

  initial begin
    bus.u_in = '0;
    bus.u_valid = 1'b0;

    // Reset state
    do_reset();
    check("rst_y_out", longint'(bus.y_out), 0);
    check("rst_y_valid", longint'(bus.y_valid), 0);
    check("rst_u_ready", longint'(bus.u_ready), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_overrun", longint'(overrun), 0);
    check("rst_state", longint'(dbg_state), longint'(IDLE));

    // 1: half/half IIR step response, 10-clock sample period
    coef_a = HALF; coef_b = HALF; delay_len = 4'd0; sample_div = 16'd9;
    enable = 1'b1;
    bus.u_in = 16'sd100;
    bus.u_valid = 1'b1;
    wait_y(4);
    bus.u_valid = 1'b0;
    check("t1_y0", obs_y(0), 50);
    check("t1_y1", obs_y(1), 75);
    check("t1_y2", obs_y(2), 87);
    check("t1_y3", obs_y(3), 93);
    for (int i = 0; i + 1 < obs_t_q.size(); i++)
      check("t1_spacing", obs_t_q[i+1] - obs_t_q[i], 10);
    check("t1_overrun", longint'(overrun), 0);

    // 2: pure dead time of 3 samples
    do_reset();
    coef_a = '0; coef_b = ONE; delay_len = 4'd3; sample_div = 16'd9;
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) send_u(16'(i), hs);
    wait_y(6);
    check("t2_y0", obs_y(0), 0);
    check("t2_y1", obs_y(1), 0);
    check("t2_y2", obs_y(2), 0);
    check("t2_y3", obs_y(3), 1);
    check("t2_y4", obs_y(4), 2);
    check("t2_y5", obs_y(5), 3);

    // 3: saturation in both directions
    do_reset();
    coef_a = '0; coef_b = 16'sh7F00; delay_len = 4'd0; sample_div = 16'd9;
    enable = 1'b1;
    send_u(16'sd1000, hs);
    send_u(-16'sd1000, hs);
    wait_y(2);
    check("t3_pos", obs_y(0), 32767);
    check("t3_neg", obs_y(1), -32768);
    check("t3_sat", longint'(sat), 1);
    check("t3_overrun", longint'(overrun), 0);

    // 4: late u_valid, ticks pile up as overruns
    do_reset();
    coef_a = '0; coef_b = ONE; delay_len = 4'd0; sample_div = 16'd2;
    enable = 1'b1;
    for (int i = 0; i < 20 && !bus.u_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    n0 = obs_y_q.size();
    repeat (10) @(posedge clk);
    #1;
    check("t4_u_ready", longint'(bus.u_ready), 1);
    check("t4_overrun", longint'(overrun), 1);
    check("t4_no_y", obs_y_q.size(), n0);
    send_u(16'sd77, hs);
    wait_y(1);
    check("t4_latency", obs_t_q.size() > 0 ? obs_t_q[0] - hs : -1, 3);
    check("t4_y", obs_y(0), 77);

    // 5: enable dropped in UPDATE discards the sample but keeps the ring write
    do_reset();
    coef_a = HALF; coef_b = ONE; delay_len = 4'd2; sample_div = 16'd9;
    enable = 1'b1;
    send_u(16'sd10, hs);
    send_u(16'sd20, hs);
    send_u(16'sd30, hs);
    wait_y(3);
    check("t5_y2", obs_y(2), 10);
    y_save = y_model;
    send_u(16'sd40, hs);
    @(posedge clk); #1;
    check("t5_in_update", longint'(dbg_state), longint'(UPDATE));
    enable = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_due_q.pop_back());
    void'(exp_clip_q.pop_back());
    y_model = y_save;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_y", obs_y_q.size(), 3);
    check("t5_y_held", longint'(bus.y_out), 10);
    check("t5_u_ready_off", longint'(bus.u_ready), 0);
    enable = 1'b1;
    send_u(16'sd50, hs);
    send_u(16'sd60, hs);
    wait_y(5);
    check("t5_after0", obs_y(3), 35);
    check("t5_after1", obs_y(4), 57);

    // 6: asynchronous reset while in DELAY
    do_reset();
    coef_a = HALF; coef_b = HALF; delay_len = 4'd0; sample_div = 16'd9;
    enable = 1'b1;
    send_u(16'sd100, hs);
    wait_y(1);
    send_u(16'sd100, hs);
    check("t6_in_delay", longint'(dbg_state), longint'(DELAY));
    rst_n = 1'b0;
    #1;
    check("t6_y_out", longint'(bus.y_out), 0);
    check("t6_y_valid", longint'(bus.y_valid), 0);
    check("t6_u_ready", longint'(bus.u_ready), 0);
    check("t6_state", longint'(dbg_state), longint'(IDLE));
    do_reset();
    enable = 1'b1;
    send_u(16'sd100, hs);
    wait_y(1);
    check("t6_fresh", obs_y(0), 50);

    // Randomized traffic against the model
    do_reset();
    total = 0;
    for (int r = 0; r < 4; r++) begin
      enable = 1'b0;
      @(posedge clk); #1;
      coef_a     = 16'($urandom_range(0, 16'h01FF)) - 16'sh0100;
      coef_b     = (r == 3) ? 16'($urandom_range(16'h4000, 16'h7FFF))
                            : 16'($urandom_range(0, 16'h01FF)) - 16'sh0100;
      delay_len  = 4'($urandom_range(0, 15));
      sample_div = 16'($urandom_range(10, 15));
      enable = 1'b1;
      for (int k = 0; k < 12; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send_u(16'($urandom), hs);
        total++;
      end
      wait_y(total);
    end
    check("rand_overrun", longint'(overrun), 0);
    check("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
